// File: rtl/em_scan_ctl.sv
// em_scan_ctl -- scan sequencer for the LVDA error-monitor latch bank.
//
// Watches the group-pending flags of the two reset ranks (rank 1 = EM1-13,
// rank 2 = EM14-26), picks a rank round-robin, snapshots its latches,
// reports each nonzero group to telemetry over a REQ/ACK handshake and then
// pulses that rank's EMRS reset. A rank whose latches come back identical
// STUCK_LIMIT times in a row is flagged stuck and no longer serviced.
//
// Optional build macro: EM_SCAN_MASK_EN adds EM_MASK and derives pending
// internally from the masked latch outputs (EMRG is then unused).
//
// Ports:
//   SIM_CLK   clock
//   SIM_RST   asynchronous active-high reset
//   V1        timing strobe; pending is sampled only while V1=1
//   EMN       latch outputs, active low, bit i = EM(i+1)N
//   EMRG      group-pending flags (groups 0..3), valid while V1=1
//   EM_MASK   (EM_SCAN_MASK_EN only) 1 = ignore that EM bit
//   TLM_ACK   telemetry accepts the current word
//   TLM_REQ   telemetry word valid
//   TLM_DATA  [8:7] group id, [6:0] active-high error bits
//   EMRS1     rank-1 reset pulse
//   EMRS2     rank-2 reset pulse
//   BUSY      sequencer not idle
//   STUCK     sticky per-rank stuck flags
module em_scan_ctl #(
  parameter int unsigned RS_CYCLES     = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STUCK_LIMIT   = 3
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        V1,
  input  logic [25:0] EMN,
  input  logic [3:0]  EMRG,
`ifdef EM_SCAN_MASK_EN
  input  logic [25:0] EM_MASK,
`endif
  input  logic        TLM_ACK,
  output logic        TLM_REQ,
  output logic [8:0]  TLM_DATA,
  output logic        EMRS1,
  output logic        EMRS2,
  output logic        BUSY,
  output logic [1:0]  STUCK
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_SEND_LO,
    S_SEND_HI,
    S_RESET,
    S_SETTLE
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;          // rank being serviced (0 = rank 1)
  logic             ptr_q, ptr_d;          // last serviced rank
  logic [3:0]       cnt_q, cnt_d;          // RESET / SETTLE cycle counter
  logic [6:0]       snap_lo_q, snap_lo_d;
  logic [5:0]       snap_hi_q, snap_hi_d;
  logic [1:0][12:0] prev_q, prev_d;        // last nonzero snapshot per rank
  logic [1:0][2:0]  stk_q, stk_d;          // consecutive-identical counters
  logic [1:0]       stuck_q, stuck_d;
  logic             req_q, req_d;
  logic [8:0]       data_q, data_d;
  logic [1:0]       emrs_q, emrs_d;
  logic             busy_q, busy_d;

  logic [25:0]      em_act;                // active-high, masked latch state
  logic [1:0]       rank_pend;
  logic [1:0]       elig;
  logic [12:0]      cur;                   // selected rank's live latch bits

`ifdef EM_SCAN_MASK_EN
  assign em_act    = ~EMN & ~EM_MASK;
  assign rank_pend = {|em_act[25:13], |em_act[12:0]};
`else
  assign em_act    = ~EMN;
  assign rank_pend = {EMRG[3] | EMRG[2], EMRG[1] | EMRG[0]};
`endif

  assign elig = V1 ? (rank_pend & ~stuck_q) : 2'b00;
  assign cur  = sel_q ? em_act[25:13] : em_act[12:0];

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      snap_lo_q <= '0;
      snap_hi_q <= '0;
      prev_q    <= '0;
      stk_q     <= '0;
      stuck_q   <= '0;
      req_q     <= 1'b0;
      data_q    <= '0;
      emrs_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      snap_lo_q <= snap_lo_d;
      snap_hi_q <= snap_hi_d;
      prev_q    <= prev_d;
      stk_q     <= stk_d;
      stuck_q   <= stuck_d;
      req_q     <= req_d;
      data_q    <= data_d;
      emrs_q    <= emrs_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    snap_lo_d = snap_lo_q;
    snap_hi_d = snap_hi_q;
    prev_d    = prev_q;
    stk_d     = stk_q;
    stuck_d   = stuck_q;
    req_d     = req_q;
    data_d    = data_q;

    case (state_q)
      S_IDLE: begin
        if (elig != 2'b00) begin
          sel_d   = (elig == 2'b11) ? ~ptr_q : elig[1];
          state_d = S_SNAP;
        end
      end

      S_SNAP: begin
        if (cur == '0) begin
          state_d = S_IDLE;
        end else begin
          snap_lo_d     = cur[6:0];
          snap_hi_d     = cur[12:7];
          prev_d[sel_q] = cur;
          if (cur == prev_q[sel_q])
            stk_d[sel_q] = (stk_q[sel_q] == 3'd7) ? 3'd7 : stk_q[sel_q] + 3'd1;
          else
            stk_d[sel_q] = 3'd1;
          state_d = S_SEND_LO;
        end
      end

      // REQ is raised one cycle after entering a send state and dropped on
      // the accepting edge, so a held ACK yields at most one word per two
      // cycles and the next state always starts with REQ low.
      S_SEND_LO: begin
        if (snap_lo_q == '0) begin
          state_d = S_SEND_HI;
        end else if (!req_q) begin
          req_d  = 1'b1;
          data_d = {sel_q, 1'b0, snap_lo_q};
        end else if (TLM_ACK) begin
          req_d   = 1'b0;
          data_d  = '0;
          state_d = S_SEND_HI;
        end
      end

      S_SEND_HI: begin
        if (snap_hi_q == '0) begin
          cnt_d   = '0;
          state_d = S_RESET;
        end else if (!req_q) begin
          req_d  = 1'b1;
          data_d = {sel_q, 1'b1, 1'b0, snap_hi_q};
        end else if (TLM_ACK) begin
          req_d   = 1'b0;
          data_d  = '0;
          cnt_d   = '0;
          state_d = S_RESET;
        end
      end

      S_RESET: begin
        ptr_d = sel_q;
        if (cnt_q == 4'(RS_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
          if (stk_q[sel_q] >= 3'(STUCK_LIMIT))
            stuck_d[sel_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they change cleanly
    // on the clock edge and drop together on asynchronous reset.
    emrs_d = '0;
    if (state_d == S_RESET)
      emrs_d[sel_d] = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  assign TLM_REQ  = req_q;
  assign TLM_DATA = data_q;
  assign EMRS1    = emrs_q[0];
  assign EMRS2    = emrs_q[1];
  assign BUSY     = busy_q;
  assign STUCK    = stuck_q;

endmodule

// File: tb/tb_em_scan_ctl.sv
// Directed self-checking bench for em_scan_ctl (default parameters).
// The bench plays the role of the latch bank: when it sees a rank's EMRS
// pulse it releases that rank's EMN bits and EMRG flags.
module tb_em_scan_ctl;

  logic        SIM_CLK;
  logic        SIM_RST;
  logic        V1;
  logic [25:0] EMN;
  logic [3:0]  EMRG;
`ifdef EM_SCAN_MASK_EN
  logic [25:0] EM_MASK;
`endif
  logic        TLM_ACK;
  logic        TLM_REQ;
  logic [8:0]  TLM_DATA;
  logic        EMRS1;
  logic        EMRS2;
  logic        BUSY;
  logic [1:0]  STUCK;

  int checks   = 0;
  int failures = 0;

  em_scan_ctl #(
    .RS_CYCLES    (2),
    .SETTLE_CYCLES(4),
    .STUCK_LIMIT  (3)
  ) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .V1      (V1),
    .EMN     (EMN),
    .EMRG    (EMRG),
`ifdef EM_SCAN_MASK_EN
    .EM_MASK (EM_MASK),
`endif
    .TLM_ACK (TLM_ACK),
    .TLM_REQ (TLM_REQ),
    .TLM_DATA(TLM_DATA),
    .EMRS1   (EMRS1),
    .EMRS2   (EMRS2),
    .BUSY    (BUSY),
    .STUCK   (STUCK)
  );

  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a word, check it, and with ACK high check REQ drops.
  task automatic run_word(input string tag, input logic [8:0] exp);
    int n;
    n = 0;
    while (TLM_REQ !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, TLM_REQ}, 32'd1);
    chk({tag, "_data"}, {23'd0, TLM_DATA}, {23'd0, exp});
    if (TLM_ACK) begin
      tick();
      chk({tag, "_req_drop"}, {31'd0, TLM_REQ}, 32'd0);
    end
  endtask

  // Wait (bounded) for an EMRS pulse; check which rank, length, exclusivity.
  task automatic measure_rs(input string tag, input logic [1:0] exp_rs);
    int n;
    int len;
    logic bad;
    n = 0;
    while (!(EMRS1 | EMRS2) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_rs_sel"}, {30'd0, EMRS2, EMRS1}, {30'd0, exp_rs});
    len = 0;
    bad = 1'b0;
    while ((EMRS1 | EMRS2) && len < 50) begin
      if ({EMRS2, EMRS1} !== exp_rs || TLM_REQ !== 1'b0) bad = 1'b1;
      tick();
      len++;
    end
    chk({tag, "_rs_len"}, len, 32'd2);
    chk({tag, "_rs_clean"}, {31'd0, bad}, 32'd0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (BUSY && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_rank1();
    EMN[12:0] = '1;
    EMRG[1:0] = 2'b00;
  endtask

  task automatic clear_rank2();
    EMN[25:13] = '1;
    EMRG[3:2]  = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic bad;
    logic busy_seen;

    SIM_RST = 1'b1;
    V1      = 1'b0;
    EMN     = '1;
    EMRG    = 4'b0000;
    TLM_ACK = 1'b1;
`ifdef EM_SCAN_MASK_EN
    EM_MASK = '0;
`endif
    #12;
    chk("rst_outputs", {18'd0, TLM_REQ, TLM_DATA, EMRS1, EMRS2, BUSY, STUCK}, 32'd0);
    SIM_RST = 1'b0;
    tick();
    chk("rst_idle_busy", {31'd0, BUSY}, 32'd0);

    // EM3 with a single V1 strobe
    EMN[2] = 1'b0;
    EMRG   = 4'b0001;
    V1     = 1'b1;
    tick();
    V1 = 1'b0;
    chk("t1_busy", {31'd0, BUSY}, 32'd1);
    run_word("t1", 9'b00_0000100);
    measure_rs("t1", 2'b01);
    clear_rank1();
    wait_idle(n);
    chk("t1_settle", n, 32'd4);
    chk("t1_busy_low", {31'd0, BUSY}, 32'd0);

    // EM21 alone: services rank 2 so the pointer now points at rank 2
    V1      = 1'b1;
    EMN[20] = 1'b0;
    EMRG    = 4'b1000;
    run_word("t2", 9'b11_0000001);
    measure_rs("t2", 2'b10);
    clear_rank2();
    wait_idle(n);

    // EM9 + EM26 both pending: last serviced was rank 2 -> rank 1 first
    EMN[8]  = 1'b0;
    EMN[25] = 1'b0;
    EMRG    = 4'b1011;
    run_word("t3a", 9'b01_0000010);
    measure_rs("t3a", 2'b01);
    clear_rank1();
    wait_idle(n);
    chk("t3a_settle", n, 32'd4);
    run_word("t3b", 9'b11_0100000);
    measure_rs("t3b", 2'b10);
    clear_rank2();
    wait_idle(n);

    // ACK withheld for 10 cycles on EM5
    TLM_ACK = 1'b0;
    EMN[4]  = 1'b0;
    EMRG    = 4'b0001;
    run_word("t4", 9'b00_0010000);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (TLM_REQ !== 1'b1 || TLM_DATA !== 9'b00_0010000 || EMRS1 || EMRS2) bad = 1'b1;
    end
    chk("t4_hold", {31'd0, bad}, 32'd0);
    TLM_ACK = 1'b1;
    tick();
    chk("t4_req_drop", {31'd0, TLM_REQ}, 32'd0);
    tick();
    chk("t4_single", {31'd0, TLM_REQ}, 32'd0);
    measure_rs("t4", 2'b01);
    clear_rank1();
    wait_idle(n);

    // EM14 never clears: stuck after the third identical snapshot
    EMN[13] = 1'b0;
    EMRG[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_word("t5", 9'b10_0000001);
      measure_rs("t5", 2'b10);
      chk("t5_stuck", {30'd0, STUCK}, (i == 2) ? 32'd2 : 32'd0);
      wait_idle(n);
    end
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (BUSY) busy_seen = 1'b1;
    end
    chk("t5_excluded", {31'd0, busy_seen}, 32'd0);
    EMN[0]  = 1'b0;
    EMRG[0] = 1'b1;
    run_word("t5_em1", 9'b00_0000001);
    measure_rs("t5_em1", 2'b01);
    clear_rank1();
    wait_idle(n);

    // Glitch: pending flag with no latch set
    EMN       = '1;
    EMRG      = 4'b0001;
    bad       = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TLM_REQ || EMRS1 || EMRS2) bad = 1'b1;
      if (BUSY) busy_seen = 1'b1;
    end
    chk("t6_no_activity", {31'd0, bad}, 32'd0);
`ifndef EM_SCAN_MASK_EN
    chk("t6_snap_seen", {31'd0, busy_seen}, 32'd1);
`endif
    V1   = 1'b0;
    EMRG = 4'b0000;
    tick();
    tick();
    chk("t6_idle", {31'd0, BUSY}, 32'd0);
    V1 = 1'b1;

`ifdef EM_SCAN_MASK_EN
    EM_MASK   = 26'h1;
    EMN[0]    = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (BUSY) busy_seen = 1'b1;
    end
    chk("tm_masked_idle", {31'd0, busy_seen}, 32'd0);
    EMN[1] = 1'b0;
    run_word("tm", 9'b00_0000010);
    measure_rs("tm", 2'b01);
    clear_rank1();
    wait_idle(n);
    EM_MASK = '0;
`endif

    // Asynchronous reset while EMRS1 is high
    chk("t7_stuck_pre", {30'd0, STUCK}, 32'd2);
    EMN[1] = 1'b0;
    EMRG   = 4'b0001;
    run_word("t7", 9'b00_0000010);
    n = 0;
    while (!EMRS1 && n < 200) begin
      tick();
      n++;
    end
    chk("t7_emrs1_up", {31'd0, EMRS1}, 32'd1);
    #2;
    SIM_RST = 1'b1;
    #1;
    chk("t7_emrs1", {31'd0, EMRS1}, 32'd0);
    chk("t7_busy", {31'd0, BUSY}, 32'd0);
    chk("t7_req", {31'd0, TLM_REQ}, 32'd0);
    chk("t7_stuck", {30'd0, STUCK}, 32'd0);
    V1   = 1'b0;
    EMRG = 4'b0000;
    EMN  = '1;
    #3;
    SIM_RST = 1'b0;
    tick();
    chk("t7_post_idle", {29'd0, BUSY, EMRS1, EMRS2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
